// File: rtl/belfft_mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : belfft_mem_arb_if
//  Purpose  : One Avalon-MM link (command + pipelined read return).
//             The master modport issues commands; the slave modport
//             accepts them and returns read data.
//  Revision : 1.0  initial release
// ============================================================================
interface belfft_mem_arb_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [AWIDTH-1:0] address;
  logic [DWIDTH-1:0] writedata;
  logic              read;
  logic              write;
  logic              waitrequest;
  logic [DWIDTH-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, writedata, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface
`default_nettype wire

// File: rtl/belfft_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : belfft_mem_arb
//  Purpose  : Two-port Avalon-MM arbiter sharing one memory slave between
//             the FFT core (m0) and a second requester (m1). One command is
//             forwarded at a time, the grant is held while a command stalls,
//             and a read-ID FIFO routes each readdatavalid back to its issuer.
//  Options  : BELFFT_ARB_FIXED_PRIO_EN - unlocked selection becomes fixed
//             priority (m0 wins whenever eligible); default is round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module belfft_mem_arb #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MAX_PENDING = 4
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  belfft_mem_arb_if.slave   m0,
  belfft_mem_arb_if.slave   m1,
  belfft_mem_arb_if.master  mem,
  output logic              err_o
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam logic [PW:0] c_full = (PW+1)'(MAX_PENDING);

  // ST_HOLD: a stalled command owns the memory until it is accepted
  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_gnt;
`ifndef BELFFT_ARB_FIXED_PRIO_EN
  logic                   r_last;
`endif
  logic [MAX_PENDING-1:0] r_fifo;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW:0]            r_count;
  logic                   r_err;

  logic              w_full;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_sel_vld;
  logic              w_sel;
  logic              w_sel_rd;
  logic              w_sel_wr;
  logic              w_accept;
  logic              w_stall;
  logic              w_push;
  logic              w_pop;
  logic              w_stray;
  logic              w_head;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_wdata;

  // Port selection: held grant wins, otherwise pick among eligible requesters
  always_comb begin
    w_full    = (r_count == c_full);
    w_elig0   = m0.write | (m0.read & ~w_full);
    w_elig1   = m1.write | (m1.read & ~w_full);
    w_sel_vld = 1'b0;
    w_sel     = 1'b0;
    if (rst_i) begin
      w_sel_vld = 1'b0;
    end else if (r_state == ST_HOLD) begin
      w_sel_vld = 1'b1;
      w_sel     = r_gnt;
    end else begin
`ifdef BELFFT_ARB_FIXED_PRIO_EN
      if (w_elig0) begin
        w_sel_vld = 1'b1;
        w_sel     = 1'b0;
      end else if (w_elig1) begin
        w_sel_vld = 1'b1;
        w_sel     = 1'b1;
      end
`else
      if (w_elig0 && w_elig1) begin
        w_sel_vld = 1'b1;
        w_sel     = ~r_last;
      end else if (w_elig0) begin
        w_sel_vld = 1'b1;
        w_sel     = 1'b0;
      end else if (w_elig1) begin
        w_sel_vld = 1'b1;
        w_sel     = 1'b1;
      end
`endif
    end
  end

  // Command mux and handshake back to the masters
  always_comb begin
    w_addr   = w_sel ? m1.address   : m0.address;
    w_wdata  = w_sel ? m1.writedata : m0.writedata;
    w_sel_rd = w_sel_vld & (w_sel ? m1.read  : m0.read);
    w_sel_wr = w_sel_vld & (w_sel ? m1.write : m0.write);
    w_accept = (w_sel_rd | w_sel_wr) & ~mem.waitrequest;
    w_stall  = (w_sel_rd | w_sel_wr) &  mem.waitrequest;
    w_push   = w_accept & w_sel_rd;
    // Responses during reset are dropped entirely
    w_pop    = ~rst_i & mem.readdatavalid & (r_count != '0);
    w_stray  = ~rst_i & mem.readdatavalid & (r_count == '0);
    w_head   = r_fifo[r_rd_ptr];
  end

  assign mem.address       = w_addr;
  assign mem.writedata     = w_wdata;
  assign mem.read          = w_sel_rd;
  assign mem.write         = w_sel_wr;
  assign m0.waitrequest    = ~(w_sel_vld & ~w_sel & ~mem.waitrequest);
  assign m1.waitrequest    = ~(w_sel_vld &  w_sel & ~mem.waitrequest);
  assign m0.readdata       = mem.readdata;
  assign m1.readdata       = mem.readdata;
  assign m0.readdatavalid  = w_pop & ~w_head;
  assign m1.readdatavalid  = w_pop &  w_head;
  assign err_o             = r_err;

  // Lock next-state: a stall holds the grant, anything else releases it
  always_comb begin
    w_state_nxt = ST_OPEN;
    if (w_stall) begin
      w_state_nxt = ST_HOLD;
    end
  end

  // State, grant history, read-ID FIFO and sticky error
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_OPEN;
      r_gnt    <= 1'b0;
`ifndef BELFFT_ARB_FIXED_PRIO_EN
      r_last   <= 1'b1;
`endif
      r_fifo   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_stall) begin
        r_gnt <= w_sel;
      end
`ifndef BELFFT_ARB_FIXED_PRIO_EN
      if (w_accept) begin
        r_last <= w_sel;
      end
`endif
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      if (w_stray) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/belfft_mem_arb.md
# belfft_mem_arb

Two-port Avalon-MM arbiter that shares one external memory slave between the FFT core's master interface (port 0) and a second requester such as audio capture or display readout (port 1). It forwards one command at a time, holds the grant while a command is stalled, and tracks outstanding pipelined reads so each `readdatavalid` returns to the master that issued the read. It sits between `bel_fft_avl`'s `m_*` port and the SDRAM/on-chip memory controller.

## Interface
Parameters:
- `AWIDTH`, 32: address width, equal to `BEL_FFT_MIF_AWIDTH`.
- `DWIDTH`, 32: data width, equal to `BEL_FFT_DWIDTH`.
- `MAX_PENDING`, 4: outstanding-read FIFO depth; must be a power of two, ≥2.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `m0_address` / `m1_address` in AWIDTH: master addresses.
- `m0_writedata` / `m1_writedata` in DWIDTH: write data.
- `m0_read`, `m0_write`, `m1_read`, `m1_write` in 1: command strobes; read and write are never both high on one port.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to each master.
- `m0_readdata`, `m1_readdata` out DWIDTH: both driven from `mem_readdata`.
- `m0_readdatavalid`, `m1_readdatavalid` out 1: routed read return.
- `mem_address` out AWIDTH, `mem_writedata` out DWIDTH, `mem_read` out 1, `mem_write` out 1: memory command.
- `mem_waitrequest` in 1, `mem_readdata` in DWIDTH, `mem_readdatavalid` in 1: memory response.
- `err_o` out 1: sticky flag, unexpected `mem_readdatavalid`.

## Operation
- State: `locked` (1b), `gnt` (1b, granted port), `last` (1b, last accepted port), read-ID FIFO (MAX_PENDING × 1b, with pointers and count), `err_o`.
- Request of port n: `mn_read | mn_write`. A read request is *eligible* only if FIFO not full; a write is always eligible.
- Selection, when `locked`=0: among eligible requesters pick round-robin: if both eligible, pick `~last`; if one, pick it; if none, no command.
- When `locked`=1: selected port is `gnt`, regardless of the other port.
- The selected port's address/data/strobes drive `mem_*` combinationally; unselected `mem_read`/`mem_write` = 0 when nothing is selected.
- `mn_waitrequest` = 1 unless port n is selected and `mem_waitrequest`=0. Non-requesting ports see waitrequest=1 (harmless).
- Accept = selected command with `mem_waitrequest`=0. On accept: `locked`←0, `last`←selected port; if read, push port ID.
- Stall = selected command with `mem_waitrequest`=1: `locked`←1, `gnt`←selected port (command must stay stable per Avalon).
- Locked read with FIFO full cannot occur (lock only taken on an eligible read).
- Return: on `mem_readdatavalid`, pop FIFO head h; assert `mh_readdatavalid` same cycle. Push and pop in the same cycle allowed (count unchanged). A pop that frees the last slot does not make a read eligible until the next cycle.
- `mem_readdatavalid` with empty FIFO: both `readdatavalid` outputs stay 0, `err_o`←1 until reset.

## Timing
- Command path: zero latency, combinational master→memory and `mem_waitrequest`→master.
- Return path: zero latency, `mem_readdatavalid`→`mh_readdatavalid` same cycle.
- Back-to-back accepts from alternating ports: one per cycle, no bubble.
- Reset (`rst_i`=1, sampled at edge): `locked`=0, `last`=1 (port 0 wins first tie), FIFO empty, `err_o`=0. While `rst_i` is high, combinationally: `mem_read`=`mem_write`=0, `m0/m1_waitrequest`=1, `m0/m1_readdatavalid`=0.
- Reset mid-transaction drops all pending IDs; responses arriving afterwards set `err_o`.

## Configuration
- `BELFFT_ARB_FIXED_PRIO_EN` defined: unlocked selection is fixed priority, port 0 (FFT core) wins whenever eligible; `last` is unused.
- Not defined: round-robin as above (default).

## Test plan
- Single read port 0 at 0x100, memory returns 0xDEADBEEF 3 cycles later -> `m0_readdatavalid`=1 with that data, `m1_readdatavalid`=0, FIFO empty after.
- Both ports write every cycle, `mem_waitrequest`=0, out of reset -> accepts alternate 0,1,0,1; with `BELFFT_ARB_FIXED_PRIO_EN` -> port 0 only while it requests.
- Port 0 read stalled 4 cycles by `mem_waitrequest`, port 1 requests throughout -> `mem_address` stays port 0's for all 5 cycles, port 1 granted on cycle 6.
- MAX_PENDING=4: interleaved reads 0,1,0,1 with no returns -> 5th read stalls (`mem_read`=0), concurrent port 1 write still accepted; four returns route 0,1,0,1 in order.
- `mem_readdatavalid` with empty FIFO -> no master valid, `err_o`=1 held; `rst_i` pulse -> `err_o`=0.
- Assert `rst_i` with 2 reads outstanding -> outputs at reset values that cycle, FIFO empty after; late return sets `err_o`.
